// File: rtl/xc_lut_opseq_pkg.sv
// xc_lut_opseq_pkg: shared widths, FSM encoding and latency for the xc.lut sequencer
package xc_lut_opseq_pkg;
  localparam int RF_AW = 5;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FETCH12 = 3'd1,
    S_FETCH3 = 3'd2,
    S_EXEC = 3'd3,
    S_RESP = 3'd4
  } state_t;
`ifdef XC_LUT_FUSED_EN
  localparam int XC_LUT_LATENCY = 3;
`else
  localparam int XC_LUT_LATENCY = 4;
`endif
endpackage

// File: rtl/xc_lut_opseq_if.sv
// xc_lut_opseq_if: request, GPR read-port and response signals of the xc.lut sequencer
interface xc_lut_opseq_if;
  import xc_lut_opseq_pkg::*;
  logic flush;
  logic req_valid;
  logic req_ready;
  logic [RF_AW-1:0] req_rs1;
  logic [RF_AW-1:0] req_rs2;
  logic [RF_AW-1:0] req_rs3;
  logic [RF_AW-1:0] req_rd;
  logic [RF_AW-1:0] rf_ra;
  logic [RF_AW-1:0] rf_rb;
  logic [XLEN-1:0] rf_da;
  logic [XLEN-1:0] rf_db;
  logic rsp_valid;
  logic rsp_ready;
  logic [RF_AW-1:0] rsp_rd;
  logic [XLEN-1:0] rsp_data;
  modport slave (
    input flush, req_valid, req_rs1, req_rs2, req_rs3, req_rd, rf_da, rf_db, rsp_ready,
    output req_ready, rf_ra, rf_rb, rsp_valid, rsp_rd, rsp_data
  );
  modport master (
    output flush, req_valid, req_rs1, req_rs2, req_rs3, req_rd, rf_da, rf_db, rsp_ready,
    input req_ready, rf_ra, rf_rb, rsp_valid, rsp_rd, rsp_data
  );
endinterface

// File: rtl/xc_lut_opseq_b_lut.sv
// xc_lut_opseq_b_lut: each crs1 nibble selects one of 16 nibbles from {crs3, crs2}
module xc_lut_opseq_b_lut (
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  input  logic [31:0] crs3,
  output logic [31:0] result
);
  logic [63:0] lut;
  assign lut = {crs3, crs2};
  for (genvar i = 0; i < 8; i++) begin : g_nib
    assign result[4*i +: 4] = lut[{crs1[4*i +: 4], 2'b00} +: 4];
  end
endmodule

// File: rtl/xc_lut_opseq.sv
// xc_lut_opseq: two-read-port operand sequencer for xc.lut; XC_LUT_FUSED_EN folds EXEC into FETCH3
module xc_lut_opseq
  import xc_lut_opseq_pkg::*;
(
  input logic g_clk,
  input logic g_resetn,
  xc_lut_opseq_if.slave io
);
  state_t state;
  logic [RF_AW-1:0] rs3;
  logic [RF_AW-1:0] rd;
  logic [XLEN-1:0] crs1;
  logic [XLEN-1:0] crs2;
  logic [XLEN-1:0] lut_c3;
  logic [XLEN-1:0] lut_out;
  logic accept;
`ifdef XC_LUT_FUSED_EN
  assign lut_c3 = io.rf_da;
`else
  logic [XLEN-1:0] crs3;
  assign lut_c3 = crs3;
`endif
  assign io.req_ready = !io.flush && (state == S_IDLE || (state == S_RESP && io.rsp_ready));
  assign accept = io.req_valid && io.req_ready;
  xc_lut_opseq_b_lut u_b_lut (.crs1(crs1), .crs2(crs2), .crs3(lut_c3), .result(lut_out));
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      state <= S_IDLE;
      rs3 <= '0;
      rd <= '0;
      crs1 <= '0;
      crs2 <= '0;
`ifndef XC_LUT_FUSED_EN
      crs3 <= '0;
`endif
      io.rf_ra <= '0;
      io.rf_rb <= '0;
      io.rsp_valid <= 1'b0;
      io.rsp_rd <= '0;
      io.rsp_data <= '0;
    end else if (io.flush) begin
      state <= S_IDLE;
      io.rf_ra <= '0;
      io.rf_rb <= '0;
      io.rsp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if (state == S_RESP && io.rsp_ready) io.rsp_valid <= 1'b0;
          if (accept) begin
            rs3 <= io.req_rs3;
            rd <= io.req_rd;
            io.rf_ra <= io.req_rs1;
            io.rf_rb <= io.req_rs2;
            state <= S_FETCH12;
          end else if (state == S_RESP && io.rsp_ready) state <= S_IDLE;
        end
        S_FETCH12: begin
          crs1 <= io.rf_da;
          crs2 <= io.rf_db;
          io.rf_ra <= rs3;
          io.rf_rb <= '0;
          state <= S_FETCH3;
        end
        S_FETCH3: begin
          io.rf_ra <= '0;
`ifdef XC_LUT_FUSED_EN
          io.rsp_data <= lut_out;
          io.rsp_rd <= rd;
          io.rsp_valid <= 1'b1;
          state <= S_RESP;
`else
          crs3 <= io.rf_da;
          state <= S_EXEC;
`endif
        end
`ifndef XC_LUT_FUSED_EN
        S_EXEC: begin
          io.rsp_data <= lut_out;
          io.rsp_rd <= rd;
          io.rsp_valid <= 1'b1;
          state <= S_RESP;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
endmodule
